// File: rtl/hero_wr_arb.sv
// hero_wr_arb: per-channel write FIFOs feeding a round-robin, burst-locked
// arbiter that drives the hero bus through one registered output stage.
module hero_wr_arb #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 36,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_last,
   output logic [1:0]                   out_cycle_type,
   output logic [DATA_WIDTH-1:0]        out_wdat,
   output logic                         out_clk_en,
   output logic [$clog2(NUM_CH)-1:0]    out_chan,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int ENT_W = DATA_WIDTH + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] CYC_IDLE  = 2'd0;
   localparam logic [1:0] CYC_VALID = 2'd1;
   localparam logic [1:0] CYC_DONE  = 2'd2;

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   // FIFO entry layout: {last, data}
   logic [ENT_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr [NUM_CH];
   logic [AW-1:0]    rd_ptr [NUM_CH];
   logic [CNT_W-1:0] count  [NUM_CH];
   logic [ENT_W-1:0] head   [NUM_CH];

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] nonempty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;

   state_t          state, state_nxt;
   logic [CH_W-1:0] rr_ptr, rr_nxt;
   logic [CH_W-1:0] lock_ch, lock_nxt;
   logic [CH_W-1:0] sel_ch;
   logic [CH_W:0]   pick;
   logic            pop_any;
   logic [1:0]      cyc_nxt;
   logic            stage_free;

   // First channel with a buffered beat, searching upward from start and
   // wrapping at NUM_CH. Result is {found, channel}.
   function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] avail,
                                             input logic [CH_W-1:0]   start);
      logic [CH_W:0] res;
      int            idx;
      res = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(start) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!res[CH_W] && avail[idx]) res = {1'b1, CH_W'(idx)};
      end
      return res;
   endfunction

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         full[i]     = (count[i] == FULL_CNT);
         nonempty[i] = (count[i] != '0);
         head[i]     = mem[i][rd_ptr[i]];
      end
   end

   assign in_ready   = ~full & {NUM_CH{~rst}};
   assign push       = in_valid & in_ready;
   assign stage_free = (out_cycle_type == CYC_IDLE) || out_ready;
   assign out_clk_en = (out_cycle_type != CYC_IDLE);
   assign busy       = (state == ST_BURST);

   // Channel FIFOs: storage is not reset, only pointers and occupancy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= {in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   always_comb begin
      pop = '0;
      if (pop_any) pop[sel_ch] = 1'b1;
   end

   // Arbiter state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         lock_ch <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         lock_ch <= lock_nxt;
      end
   end

   // Grant selection and next state; nothing moves while the output is stalled.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      lock_nxt  = lock_ch;
      sel_ch    = lock_ch;
      pop_any   = 1'b0;
      cyc_nxt   = CYC_IDLE;
      pick      = rr_pick(nonempty, rr_ptr);
      if (stage_free) begin
         if (state == ST_IDLE) begin
            if (pick[CH_W]) begin
               sel_ch  = pick[CH_W-1:0];
               pop_any = 1'b1;
            end
         end else if (nonempty[lock_ch]) begin
            pop_any = 1'b1;
         end
         if (pop_any) begin
            if (head[sel_ch][DATA_WIDTH]) begin
               cyc_nxt   = CYC_DONE;
               state_nxt = ST_IDLE;
               rr_nxt    = next_ch(sel_ch);
            end else begin
               cyc_nxt   = CYC_VALID;
               state_nxt = ST_BURST;
               lock_nxt  = sel_ch;
            end
         end
      end
   end

   // Output stage: bubbles keep the last data and channel on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_cycle_type <= CYC_IDLE;
         out_wdat       <= '0;
         out_chan       <= '0;
      end else if (stage_free) begin
         out_cycle_type <= cyc_nxt;
         if (pop_any) begin
            out_wdat <= head[sel_ch][DATA_WIDTH-1:0];
            out_chan <= sel_ch;
         end
      end
   end

endmodule

// File: tb/tb_hero_wr_arb.sv
// Randomized scoreboard bench for hero_wr_arb: accepted beats are queued per
// channel and a monitor predicts each output cycle from the arbitration rules.
module tb_hero_wr_arb;

   localparam int NCH = 4;
   localparam int DW  = 36;
   localparam int FD  = 4;
   localparam int CW  = $clog2(NCH);

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_last;
   logic [1:0]        out_cycle_type;
   logic [DW-1:0]     out_wdat;
   logic              out_clk_en;
   logic [CW-1:0]     out_chan;
   logic              out_ready;
   logic              busy;

   always #5 clk = ~clk;

   hero_wr_arb #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_cycle_type(out_cycle_type),
      .out_wdat(out_wdat), .out_clk_en(out_clk_en), .out_chan(out_chan),
      .out_ready(out_ready), .busy(busy));

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
      int            tag;   // edge number at which the beat was accepted
   } beat_t;

   beat_t sb[NCH][$];
   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: runs 1 time unit after every rising edge.
   initial begin : monitor
      logic [1:0]    p_type;
      logic [DW-1:0] p_wdat;
      logic [CW-1:0] p_chan;
      bit            m_burst, free, found;
      int            m_lock, m_rr, ch, c;
      beat_t         e;
      p_type = '0; p_wdat = '0; p_chan = '0;
      m_burst = 0; m_lock = 0; m_rr = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         free = (p_type == 2'd0) || out_ready;
         if (rst) begin
            for (int k = 0; k < NCH; k++) sb[k].delete();
            m_burst = 0; m_rr = 0;
            chk("reset_type", 64'(out_cycle_type), 64'd0);
            chk("reset_wdat", 64'(out_wdat), 64'd0);
            chk("reset_chan", 64'(out_chan), 64'd0);
         end else if (!free) begin
            chk("hold_type", 64'(out_cycle_type), 64'(p_type));
            chk("hold_wdat", 64'(out_wdat), 64'(p_wdat));
            chk("hold_chan", 64'(out_chan), 64'(p_chan));
         end else begin
            found = 0; ch = 0;
            if (m_burst) begin
               if (sb[m_lock].size() > 0 && sb[m_lock][0].tag < cyc) begin
                  found = 1; ch = m_lock;
               end
            end else begin
               for (int k = 0; k < NCH; k++) begin
                  c = (m_rr + k) % NCH;
                  if (!found && sb[c].size() > 0 && sb[c][0].tag < cyc) begin
                     found = 1; ch = c;
                  end
               end
            end
            if (found) begin
               e = sb[ch].pop_front();
               chk("beat_type", 64'(out_cycle_type), e.last ? 64'd2 : 64'd1);
               chk("beat_chan", 64'(out_chan), 64'(ch));
               chk("beat_wdat", 64'(out_wdat), 64'(e.d));
               if (e.last) begin
                  m_burst = 0; m_rr = (ch + 1) % NCH;
               end else begin
                  m_burst = 1; m_lock = ch;
               end
            end else begin
               chk("idle_type", 64'(out_cycle_type), 64'd0);
               chk("idle_wdat_held", 64'(out_wdat), 64'(p_wdat));
            end
         end
         chk("busy", 64'(busy), 64'(m_burst));
         chk("clk_en", 64'(out_clk_en), 64'(out_cycle_type != 2'd0));
         p_type = out_cycle_type; p_wdat = out_wdat; p_chan = out_chan;
      end
   end

   // Stimulus generator state
   int            budget [NCH];   // transactions still allowed to start, -1 = unlimited
   int            len_fix[NCH];   // 0 = random length
   int            rem    [NCH];
   bit            have   [NCH];
   logic [DW-1:0] cur_d  [NCH];
   bit [NCH-1:0]  vmask;
   int            p_valid, p_ready, max_len;
   bit            use_fixed;
   logic [DW-1:0] fixed_d;

   task automatic step(input bit rst_v);
      logic [63:0] r;
      @(posedge clk); #2;
      rst = rst_v;
      out_ready = ($urandom_range(99) < p_ready);
      for (int c = 0; c < NCH; c++) begin
         if (rst_v) begin
            rem[c] = 0; have[c] = 0;
         end else if (!have[c] && (rem[c] > 0 || budget[c] != 0)) begin
            if (rem[c] == 0) begin
               rem[c] = (len_fix[c] > 0) ? len_fix[c] : int'($urandom_range(max_len, 1));
               if (budget[c] > 0) budget[c]--;
            end
            r = {$urandom(), $urandom()};
            cur_d[c] = use_fixed ? fixed_d : r[DW-1:0];
            have[c]  = 1;
         end
         in_valid[c]            = have[c] && vmask[c] && !rst_v && ($urandom_range(99) < p_valid);
         in_data[c*DW +: DW]    = cur_d[c];
         in_last[c]             = (rem[c] == 1);
      end
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("in_ready_%0d", c), 64'(in_ready[c]),
             64'(!rst_v && sb[c].size() < FD));
         if (in_valid[c] && in_ready[c]) begin
            sb[c].push_back('{d: cur_d[c], last: (rem[c] == 1), tag: cyc + 1});
            have[c] = 0;
            rem[c]--;
         end
      end
   endtask

   task automatic scenario(input bit [NCH-1:0] vm, input int pv, input int pr);
      step(1'b1);
      vmask = vm; p_valid = pv; p_ready = pr;
      use_fixed = 0;
      for (int c = 0; c < NCH; c++) begin
         budget[c] = 0; len_fix[c] = 0;
      end
   endtask

   initial begin : driver
      bit done;
      rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
      vmask = '0; p_valid = 100; p_ready = 100; max_len = 4; use_fixed = 0; fixed_d = '0;
      for (int c = 0; c < NCH; c++) begin
         budget[c] = 0; len_fix[c] = 0; rem[c] = 0; have[c] = 0; cur_d[c] = '0;
      end
      repeat (3) step(1'b1);

      // single beat 0xA5 on channel 2
      scenario(4'b0100, 100, 100);
      budget[2] = 1; len_fix[2] = 1; use_fixed = 1; fixed_d = 36'hA5;
      repeat (5) step(1'b0);

      // burst lock: ch0 three beats, ch1 one beat at the same time
      scenario(4'b0011, 100, 100);
      budget[0] = 1; len_fix[0] = 3; budget[1] = 1; len_fix[1] = 1;
      repeat (8) step(1'b0);

      // round robin: two rounds of single-beat transactions on every channel
      scenario(4'b1111, 100, 100);
      for (int c = 0; c < NCH; c++) begin budget[c] = 1; len_fix[c] = 1; end
      step(1'b0);
      for (int c = 0; c < NCH; c++) budget[c] = 1;
      repeat (12) step(1'b0);

      // backpressure until ch0 fills, then release
      scenario(4'b0001, 100, 0);
      budget[0] = 1; len_fix[0] = 5;
      repeat (8) step(1'b0);
      p_ready = 100;
      repeat (8) step(1'b0);

      // bubble: ch0 stalls three cycles inside a two-beat burst
      scenario(4'b0001, 100, 100);
      budget[0] = 1; len_fix[0] = 2;
      step(1'b0);
      vmask = '0;
      repeat (3) step(1'b0);
      vmask = 4'b0001;
      repeat (4) step(1'b0);

      // reset in the middle of a four-beat burst, then a fresh transaction
      scenario(4'b0001, 100, 100);
      budget[0] = 1; len_fix[0] = 4;
      repeat (3) step(1'b0);
      step(1'b1);
      vmask = 4'b0010; budget[1] = 1; len_fix[1] = 1;
      repeat (5) step(1'b0);

      // randomized traffic
      for (int seg = 0; seg < 40; seg++) begin
         if ($urandom_range(7) == 0) step(1'b1);
         vmask   = NCH'($urandom_range(15, 1));
         p_valid = $urandom_range(100, 20);
         p_ready = ($urandom_range(3) == 0) ? int'($urandom_range(30)) : int'($urandom_range(100, 50));
         max_len = $urandom_range(6, 1);
         for (int c = 0; c < NCH; c++) begin budget[c] = -1; len_fix[c] = 0; end
         repeat (80) step(1'b0);
      end

      // drain: finish open transactions, start no new ones
      vmask = '1; p_valid = 100; p_ready = 100;
      for (int c = 0; c < NCH; c++) budget[c] = 0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         step(1'b0);
         done = !busy && (out_cycle_type == 2'd0);
         for (int c = 0; c < NCH; c++)
            if (sb[c].size() != 0 || have[c] || rem[c] != 0) done = 0;
      end
      chk("drain_complete", 64'(done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
